// File: rtl/bram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_if
// Signal bundle of the BRAM stream reader: request channel, output stream
// channel and the BRAM master port. The "master" modport is the reader's
// view; the "slave" modport is the view of whatever surrounds it (request
// source, stream consumer and BRAM).
// ---------------------------------------------------------------------------
interface bram_stream_reader_if #(
   parameter int DATA_BITW = 32,
   parameter int ADDR_BITW = 32,
   parameter int LEN_BITW  = 16
);
   // request channel
   logic                   ReqValid_SI;
   logic                   ReqReady_SO;
   logic [ADDR_BITW-1:0]   ReqAddr_DI;
   logic [LEN_BITW-1:0]    ReqLen_DI;
   // output stream
   logic                   OutValid_SO;
   logic                   OutReady_SI;
   logic [DATA_BITW-1:0]   OutData_DO;
   logic                   OutLast_SO;
   logic                   Busy_SO;
   // BRAM port
   logic                   Bram_Clk_CO;
   logic                   Bram_Rst_RO;
   logic                   Bram_En_SO;
   logic [ADDR_BITW-1:0]   Bram_Addr_SO;
   logic [DATA_BITW-1:0]   Bram_Wr_DO;
   logic [DATA_BITW/8-1:0] Bram_WrEn_SO;
   logic [DATA_BITW-1:0]   Bram_Rd_DI;

   modport master (
      input  ReqValid_SI, ReqAddr_DI, ReqLen_DI, OutReady_SI, Bram_Rd_DI,
      output ReqReady_SO, OutValid_SO, OutData_DO, OutLast_SO, Busy_SO,
             Bram_Clk_CO, Bram_Rst_RO, Bram_En_SO, Bram_Addr_SO,
             Bram_Wr_DO, Bram_WrEn_SO
   );

   modport slave (
      output ReqValid_SI, ReqAddr_DI, ReqLen_DI, OutReady_SI, Bram_Rd_DI,
      input  ReqReady_SO, OutValid_SO, OutData_DO, OutLast_SO, Busy_SO,
             Bram_Clk_CO, Bram_Rst_RO, Bram_En_SO, Bram_Addr_SO,
             Bram_Wr_DO, Bram_WrEn_SO
   );
endinterface

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Takes one burst request (byte start address, word count), reads the words
// from a BRAM slave and streams them out on valid/ready with a last flag.
// A credit counter bounds the reads in flight to the depth of the output
// FIFO, so BRAM latency and downstream backpressure are absorbed without an
// overflow path.
//
// Build option: define BRAM_STREAM_READER_OUTREG_EN when the BRAM output
// register is enabled (read latency 2, FIFO depth 4). Default: latency 1,
// FIFO depth 3.
// ---------------------------------------------------------------------------
module bram_stream_reader #(
   parameter int DATA_BITW = 32,
   parameter int ADDR_BITW = 32,
   parameter int LEN_BITW  = 16
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   bram_stream_reader_if.master  bus
);

`ifdef BRAM_STREAM_READER_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif
   localparam int D      = RD_LAT + 2;
   localparam int BYTES  = DATA_BITW / 8;
   localparam int CNT_W  = $clog2(D + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [ADDR_BITW-1:0]   addr_r;
   logic [LEN_BITW-1:0]    remain_r;
   logic [CNT_W-1:0]       credit_r;
   logic [CNT_W-1:0]       fifo_cnt_r;
   logic [CNT_W-1:0]       wr_idx_s;
   logic [RD_LAT-1:0]      vld_pipe_r;
   logic [RD_LAT-1:0]      last_pipe_r;
   logic [DATA_BITW-1:0]   fifo_data_r [D];
   logic [D-1:0]           fifo_last_r;
   logic                   ready_r;
   logic                   busy_r;
   logic                   accept_s;
   logic                   issue_s;
   logic                   issue_last_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   out_valid_s;

   // Handshake decode shared by the FSM and the datapath
   always_comb begin
      out_valid_s = (fifo_cnt_r != CNT_W'(0));
      pop_s       = out_valid_s & bus.OutReady_SI;
      accept_s    = ready_r & bus.ReqValid_SI;
      push_s      = vld_pipe_r[RD_LAT-1];
      if (pop_s) begin
         wr_idx_s = fifo_cnt_r - CNT_W'(1);
      end else begin
         wr_idx_s = fifo_cnt_r;
      end
   end

   // FSM state register
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && (bus.ReqLen_DI != LEN_BITW'(0))) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (issue_last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if (pop_s && fifo_last_r[0]) begin
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs: read enables while credits remain
   always_comb begin
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
      case (state_r)
         ISSUE: begin
            issue_s      = (credit_r < CNT_W'(D));
            issue_last_s = issue_s && (remain_r == LEN_BITW'(1));
         end
         default: begin
            issue_s      = 1'b0;
            issue_last_s = 1'b0;
         end
      endcase
   end

   // Burst address and remaining-word bookkeeping
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         addr_r   <= '0;
         remain_r <= '0;
      end else if ((state_r == IDLE) && accept_s) begin
         addr_r   <= bus.ReqAddr_DI & ~ADDR_BITW'(BYTES - 1);
         remain_r <= bus.ReqLen_DI;
      end else if (issue_s) begin
         addr_r   <= addr_r + ADDR_BITW'(BYTES);
         remain_r <= remain_r - LEN_BITW'(1);
      end
   end

   // Credits: reads issued and not yet popped
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         credit_r <= '0;
      end else begin
         case ({issue_s, pop_s})
            2'b10:   credit_r <= credit_r + CNT_W'(1);
            2'b01:   credit_r <= credit_r - CNT_W'(1);
            default: credit_r <= credit_r;
         endcase
      end
   end

   // Valid/last tags travelling alongside the BRAM read latency
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         vld_pipe_r  <= '0;
         last_pipe_r <= '0;
      end else begin
         vld_pipe_r[0]  <= issue_s;
         last_pipe_r[0] <= issue_last_s;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_r[i]  <= vld_pipe_r[i-1];
            last_pipe_r[i] <= last_pipe_r[i-1];
         end
      end
   end

   // Shifting FIFO: entry 0 is always the head, so the outputs come straight
   // from flops and hold while the consumer stalls
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int i = 0; i < D; i++) begin
            fifo_data_r[i] <= '0;
         end
         fifo_last_r <= '0;
      end else begin
         for (int i = 0; i < D - 1; i++) begin
            if (push_s && (wr_idx_s == CNT_W'(i))) begin
               fifo_data_r[i] <= bus.Bram_Rd_DI;
               fifo_last_r[i] <= last_pipe_r[RD_LAT-1];
            end else if (pop_s) begin
               fifo_data_r[i] <= fifo_data_r[i+1];
               fifo_last_r[i] <= fifo_last_r[i+1];
            end
         end
         if (push_s && (wr_idx_s == CNT_W'(D - 1))) begin
            fifo_data_r[D-1] <= bus.Bram_Rd_DI;
            fifo_last_r[D-1] <= last_pipe_r[RD_LAT-1];
         end
      end
   end

   // FIFO occupancy
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         fifo_cnt_r <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // Registered status: ready held low during reset, busy outside IDLE
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         ready_r <= (state_s == IDLE);
         busy_r  <= (state_s != IDLE);
      end
   end

   // Port drive
   always_comb begin
      bus.ReqReady_SO  = ready_r;
      bus.OutValid_SO  = out_valid_s;
      bus.OutData_DO   = fifo_data_r[0];
      bus.OutLast_SO   = fifo_last_r[0];
      bus.Busy_SO      = busy_r;
      bus.Bram_En_SO   = issue_s;
      bus.Bram_Addr_SO = addr_r;
      bus.Bram_Wr_DO   = '0;
      bus.Bram_WrEn_SO = '0;
   end

   assign bus.Bram_Clk_CO = Clk_CI;
   assign bus.Bram_Rst_RO = ~Rst_RBI;

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Master-side counterpart of the team's BRAM port bundle: drives Clk/Rst/En/Addr/Wr/WrEn toward a BRAM slave and consumes Rd.
- Accepts one burst read request (byte start address, word count) and streams the words out on a valid/ready interface with a last flag.
- Hides BRAM read latency and downstream backpressure with a credit-controlled internal FIFO.
- Sits between a BRAM (slave) and streaming consumers, e.g. DMA or packetizer logic.

Parameters:
- DATA_BITW, 32, BRAM data width in bits; multiple of 8, power of two.
- ADDR_BITW, 32, BRAM byte-address width.
- LEN_BITW, 16, width of the request word count.

Ports:
- Clk_CI  in  1  clock; every operation is synchronous to this clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- ReqValid_SI  in  1  request valid.
- ReqReady_SO  out  1  request ready; high only in IDLE.
- ReqAddr_DI  in  ADDR_BITW  byte start address.
- ReqLen_DI  in  LEN_BITW  number of words to read.
- OutValid_SO  out  1  output beat valid.
- OutReady_SI  in  1  output beat ready.
- OutData_DO  out  DATA_BITW  output word.
- OutLast_SO  out  1  final beat of the burst.
- Busy_SO  out  1  high from request acceptance until the last beat is consumed.
- Bram_Clk_CO  out  1  equals Clk_CI.
- Bram_Rst_RO  out  1  equals ~Rst_RBI.
- Bram_En_SO  out  1  BRAM enable.
- Bram_Addr_SO  out  ADDR_BITW  BRAM byte address.
- Bram_Wr_DO  out  DATA_BITW  constant 0.
- Bram_WrEn_SO  out  DATA_BITW/8  constant 0.
- Bram_Rd_DI  in  DATA_BITW  BRAM read data.

Behaviour:
- Reset state: all of the following are 0: ReqReady_SO, OutValid_SO, OutData_DO, OutLast_SO, Busy_SO, Bram_En_SO, Bram_Addr_SO. FSM = IDLE, FIFO empty, credit counter 0.
- Read latency RD_LAT = 1: data for an enable in cycle k is sampled from Bram_Rd_DI at the end of cycle k+RD_LAT.
- FIFO depth D = RD_LAT+2.
- FSM states:
  - IDLE: ReqReady_SO=1. On ReqValid_SI&ReqReady_SO, latch address with the low log2(DATA_BITW/8) bits forced to 0, and latch the remaining count = ReqLen_DI. Go to ISSUE if the count is nonzero, else stay in IDLE (zero-length request is consumed silently, no beats, Busy_SO never rises).
  - ISSUE: Bram_En_SO = (credits < D). On each enable: address += DATA_BITW/8, with modulo 2^ADDR_BITW wrap; remaining count -= 1; the enable is tagged last when remaining == 1. After the last enable, go to DRAIN.
  - DRAIN: no enables. Return to IDLE in the cycle after the last beat is popped.
- Credit counter = reads issued but not yet popped. +1 on enable, -1 on pop (OutValid_SO&OutReady_SI); both in one cycle leaves it unchanged. Never exceeds D. The FIFO therefore never overflows and there is no overflow path.
- Output:
  - OutValid_SO = FIFO not empty; OutData_DO / OutLast_SO come from the FIFO head, registered.
  - Data and last stay stable while OutValid_SO is high and OutReady_SI is low.
- Timing:
  - Request accepted at edge 0 → first Bram_En_SO in cycle 1 → first OutValid_SO in cycle 3.
  - With OutReady_SI held high, throughput is one beat per cycle.
- Busy_SO = state != IDLE.
- Reset asserted mid-burst: immediate return to the reset state. In-flight BRAM data is discarded and no partial beat is emitted after release.

Optional Feature:
- Macro: BRAM_STREAM_READER_OUTREG_EN.
- Defined: BRAM output register assumed enabled; RD_LAT = 2, D = 4. Read data is sampled two cycles after enable. First OutValid_SO arrives in cycle 4 after acceptance. Full throughput is retained.
- Undefined: RD_LAT = 1, D = 3, as above.

Test Plan:
- Basic burst: ReqAddr=0x100, Len=4, DATA_BITW=32, OutReady=1, BRAM preloaded with word i at 0x100+4i → Bram_Addr 0x100,0x104,0x108,0x10C on consecutive cycles; beats on cycles 3..6; last only on the 4th beat; ReqReady high again on cycle 7.
- Backpressure: Len=8, OutReady toggling 1-0-0-1 → no more than 3 reads outstanding; data and order intact; held beat stable while stalled.
- Unaligned and wrap (ADDR_BITW=8): ReqAddr=0xFA, Len=3 → addresses 0xF8, 0xFC, 0x00.
- Zero length: Len=0 → handshake completes; Bram_En never asserted; OutValid and Busy stay 0.
- Reset mid-burst: assert Rst_RBI low in the cycle after the 2nd beat of a Len=6 burst → all outputs 0 asynchronously; after release, IDLE with ReqReady=1 and no stale beats.
- With BRAM_STREAM_READER_OUTREG_EN defined: repeat the basic burst → first beat on cycle 4, four consecutive beats, same data.
